// File: rtl/alu_ctrl_seq.sv
// Sequenced operand loader for the board ALU: buttons are synchronised and debounced, then edge-detected, and loads are forced into the order A -> B -> opcode.
// Optional feature macro: ALU_CTRL_DEBOUNCE_EN (debounce counters); without it the synchronised level is used directly.
module ALU #(
  parameter int SIZEDATA = 8,
  parameter int SIZEOP   = 6
) (
  input  logic signed [SIZEDATA-1:0] DATOA,
  input  logic signed [SIZEDATA-1:0] DATOB,
  input  logic        [SIZEOP-1:0]   OPCODE,
  output logic signed [SIZEDATA-1:0] RESULT
);
  always_comb begin
    RESULT = '0;
    case (OPCODE)
      6'h20: RESULT = DATOA + DATOB;
      6'h22: RESULT = DATOA - DATOB;
      6'h24: RESULT = DATOA & DATOB;
      6'h25: RESULT = DATOA | DATOB;
      6'h26: RESULT = DATOA ^ DATOB;
      6'h27: RESULT = ~(DATOA | DATOB);
      6'h2A: RESULT = {{(SIZEDATA-1){1'b0}}, (DATOA < DATOB)};
      default: RESULT = '0;
    endcase
  end
endmodule

module alu_ctrl_seq #(
  parameter int SIZEDATA        = 8,
  parameter int SIZEOP          = 6,
  parameter int N_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [SIZEDATA-1:0]  SWITCHES,
  input  logic [N_BUTTONS-1:0] BUTTONS,
  output logic [SIZEDATA-1:0]  LEDS,
  output logic                 VALID,
  output logic [2:0]           STATE
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HAVE_A = 3'd1,
    HAVE_B = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Parameter sanity: these blocks are empty and exist only to flag illegal configurations.
  if (SIZEOP > SIZEDATA) begin : g_bad_sizeop
  end
  if (N_BUTTONS != 3 || DEBOUNCE_CYCLES < 2) begin : g_bad_buttons
  end

  logic [N_BUTTONS-1:0] sync_p0, sync_p1, deb, deb_q, p;
  state_t state, state_nxt;
  logic signed [SIZEDATA-1:0] datoa, datob, result;
  logic [SIZEOP-1:0] opcode;
  logic ld_a, ld_b, ld_op, ld_res, clr_valid;

  // Stage p0/p1: two-flop synchroniser on the raw buttons
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= BUTTONS;
      sync_p1 <= sync_p0;
    end
  end

`ifdef ALU_CTRL_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Debounce: level flips on the edge where the counter would reach DEBOUNCE_CYCLES-1
  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             lvl;
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync_p1[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 2)) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign deb[i] = lvl;
  end
`else
  assign deb = sync_p1;
`endif

  // Edge detect: one-cycle pulse per accepted rising level
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) deb_q <= '0;
    else       deb_q <= deb;
  end
  assign p = deb & ~deb_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    ld_res    = 1'b0;
    clr_valid = 1'b0;
    case (state)
      IDLE:   if (p[0]) begin ld_a = 1'b1; state_nxt = HAVE_A; end
      HAVE_A: if (p[1]) begin ld_b = 1'b1; state_nxt = HAVE_B; end
      HAVE_B: if (p[2]) begin ld_op = 1'b1; state_nxt = EXEC; end
      EXEC:   begin ld_res = 1'b1; state_nxt = DONE; end
      DONE:   if (p[0]) begin ld_a = 1'b1; clr_valid = 1'b1; state_nxt = HAVE_A; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      datoa  <= '0;
      datob  <= '0;
      opcode <= '0;
      LEDS   <= '0;
      VALID  <= 1'b0;
    end else begin
      if (ld_a)  datoa  <= SWITCHES;
      if (ld_b)  datob  <= SWITCHES;
      if (ld_op) opcode <= SWITCHES[SIZEOP-1:0];
      if (ld_res) begin
        LEDS  <= result;
        VALID <= 1'b1;
      end else if (clr_valid) begin
        VALID <= 1'b0;
      end
    end
  end

  ALU #(.SIZEDATA(SIZEDATA), .SIZEOP(SIZEOP)) u_alu (
    .DATOA (datoa),
    .DATOB (datob),
    .OPCODE(opcode),
    .RESULT(result)
  );

  assign STATE = state;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: table of button presses with expected STATE/LEDS/VALID plus latency, bounce and reset sequences.
module tb_alu_ctrl_seq;
  localparam int DC = 4;
`ifdef ALU_CTRL_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
  localparam int LAT = 2 + DC;
`else
  localparam bit DEB_EN = 1'b0;
  localparam int LAT = 3;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] SWITCHES;
  logic [2:0] BUTTONS;
  logic [7:0] LEDS;
  logic       VALID;
  logic [2:0] STATE;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] sw;
    int         btn;
    logic [2:0] st;
    logic [7:0] leds;
    logic       vld;
  } vec_t;
  vec_t vecs[18];

  alu_ctrl_seq #(.SIZEDATA(8), .SIZEOP(6), .N_BUTTONS(3), .DEBOUNCE_CYCLES(DC)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .SWITCHES(SWITCHES),
    .BUTTONS (BUTTONS),
    .LEDS    (LEDS),
    .VALID   (VALID),
    .STATE   (STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(input int b, input int hold);
    BUTTONS[b] = 1'b1;
    tick(hold);
    BUTTONS[b] = 1'b0;
    tick(14);
  endtask

  task automatic do_reset();
    BUTTONS = '0;
    @(negedge CLK) RESET = 1'b1;
    @(negedge CLK) RESET = 1'b0;
    tick(1);
  endtask

  initial begin
    vecs[0]  = '{8'h11, 1, 3'd0, 8'h00, 1'b0};
    vecs[1]  = '{8'h22, 2, 3'd0, 8'h00, 1'b0};
    vecs[2]  = '{8'h05, 0, 3'd1, 8'h00, 1'b0};
    vecs[3]  = '{8'h77, 0, 3'd1, 8'h00, 1'b0};
    vecs[4]  = '{8'h20, 2, 3'd1, 8'h00, 1'b0};
    vecs[5]  = '{8'h03, 1, 3'd2, 8'h00, 1'b0};
    vecs[6]  = '{8'h99, 1, 3'd2, 8'h00, 1'b0};
    vecs[7]  = '{8'h20, 2, 3'd4, 8'h08, 1'b1};
    vecs[8]  = '{8'h00, 1, 3'd4, 8'h08, 1'b1};
    vecs[9]  = '{8'hFF, 0, 3'd1, 8'h08, 1'b0};
    vecs[10] = '{8'h01, 1, 3'd2, 8'h08, 1'b0};
    vecs[11] = '{8'h22, 2, 3'd4, 8'hFE, 1'b1};
    vecs[12] = '{8'h10, 0, 3'd1, 8'hFE, 1'b0};
    vecs[13] = '{8'h30, 1, 3'd2, 8'hFE, 1'b0};
    vecs[14] = '{8'h2A, 2, 3'd4, 8'h01, 1'b1};
    vecs[15] = '{8'hF0, 0, 3'd1, 8'h01, 1'b0};
    vecs[16] = '{8'h3C, 1, 3'd2, 8'h01, 1'b0};
    vecs[17] = '{8'h24, 2, 3'd4, 8'h30, 1'b1};

    RESET = 1'b1;
    SWITCHES = '0;
    BUTTONS = '0;
    #3;
    check("reset_leds",  LEDS, 8'h00);
    check("reset_valid", {7'd0, VALID}, 8'h00);
    check("reset_state", {5'd0, STATE}, 8'h00);
    do_reset();

    // Bounce: short glitches must not reach the FSM when debounce is enabled
    SWITCHES = 8'h42;
    BUTTONS[0] = 1'b1; tick(2);
    BUTTONS[0] = 1'b0; tick(1);
    BUTTONS[0] = 1'b1; tick(2);
    BUTTONS[0] = 1'b0; tick(12);
    check("bounce_state", {5'd0, STATE}, DEB_EN ? 8'h00 : 8'h01);
    press(0, 6);
    check("hold6_state", {5'd0, STATE}, 8'h01);

    // Press-to-capture latency and opcode-to-LEDS latency
    do_reset();
    SWITCHES = 8'h05;
    BUTTONS[0] = 1'b1;
    tick(1);
    if (!DEB_EN) BUTTONS[0] = 1'b0;
    tick(LAT - 2);
    check("lat_a_before", {5'd0, STATE}, 8'h00);
    tick(1);
    check("lat_a_at", {5'd0, STATE}, 8'h01);
    BUTTONS[0] = 1'b0;
    tick(14);
    SWITCHES = 8'h03;
    press(1, 10);
    check("lat_b_state", {5'd0, STATE}, 8'h02);
    SWITCHES = 8'h20;
    BUTTONS[2] = 1'b1;
    tick(LAT - 1);
    check("lat_op_before", {5'd0, STATE}, 8'h02);
    tick(1);
    check("lat_op_state", {5'd0, STATE}, 8'h03);
    check("lat_op_valid", {7'd0, VALID}, 8'h00);
    check("lat_op_leds",  LEDS, 8'h00);
    tick(1);
    check("lat_res_state", {5'd0, STATE}, 8'h04);
    check("lat_res_valid", {7'd0, VALID}, 8'h01);
    check("lat_res_leds",  LEDS, 8'h08);
    BUTTONS[2] = 1'b0;
    tick(14);

    // Table of presses from a clean reset
    do_reset();
    for (int i = 0; i < 18; i++) begin
      SWITCHES = vecs[i].sw;
      press(vecs[i].btn, 10);
      check($sformatf("vec%0d_state", i), {5'd0, STATE}, {5'd0, vecs[i].st});
      check($sformatf("vec%0d_leds", i), LEDS, vecs[i].leds);
      check($sformatf("vec%0d_valid", i), {7'd0, VALID}, {7'd0, vecs[i].vld});
    end

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    #2;
    RESET = 1'b1;
    #1;
    check("async_leds",  LEDS, 8'h00);
    check("async_valid", {7'd0, VALID}, 8'h00);
    check("async_state", {5'd0, STATE}, 8'h00);
    @(negedge CLK) RESET = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
